// File: rtl/line_cache_ctrl_pkg.sv
// Shared types, sizes and the RGB555 -> RGB888 expansion used by the line cache controller.
package line_cache_ctrl_pkg;

  localparam int LCC_LINE_PIXELS = 240;
  localparam int LCC_NUM_LINES   = 160;
  localparam int LCC_IDX_W       = 8;

  typedef logic [14:0] rgb555_t;
  typedef logic [23:0] rgb888_t;
  typedef rgb888_t [8:0] win3x3_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME0,
    ST_PRIME1,
    ST_RUN
  } rd_state_e;

  // Replicating the top bits keeps full white at 0xFF and black at 0x00.
  function automatic rgb888_t expand555(input rgb555_t p);
    return {p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/line_cache_ctrl_line_bank.sv
// One line bank: simple dual-port RAM with a write port and a registered read port.
module lcc_line_bank
  import line_cache_ctrl_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          pxlClk,
  input  logic          wrEn_i,
  input  logic [AW-1:0] wrAddr_i,
  input  rgb555_t       wrData_i,
  input  logic [AW-1:0] rdAddr_i,
  output rgb555_t       rdData_o
);

  rgb555_t mem [2**AW];
  rgb555_t rdData_q;

  always_ff @(posedge pxlClk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_q <= mem[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/line_cache_ctrl.sv
// Four-bank line cache between GBA capture and the HDMI generator, producing a 3x3 window.
// Build option: LCC_EDGE_CLAMP_EN makes off-frame window positions replicate the nearest pixel.
module line_cache_ctrl
  import line_cache_ctrl_pkg::*;
#(
  parameter int LINE_PIXELS = LCC_LINE_PIXELS,
  parameter int NUM_LINES   = LCC_NUM_LINES,
  parameter int IDX_W       = LCC_IDX_W
) (
  input  logic             pxlClk,
  input  logic             rst,
  input  logic             wrFrameStart_i,
  input  logic             wrEn_i,
  input  rgb555_t          wrData_i,
  input  logic             wrLineEnd_i,
  input  logic [IDX_W-1:0] curPxl_i,
  input  logic             cacheUpdate_i,
  input  logic             nextLine_i,
  output logic             sameLine_o,
  output win3x3_t          win_o,
  output logic             winValid_o
);

`ifdef LCC_EDGE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  localparam int                LINE_W    = $clog2(NUM_LINES);
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(LINE_PIXELS);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);

  logic [1:0]        topPtr_q, topPtr_d;
  logic [3:0]        complete_q, complete_d;
  logic [IDX_W-1:0]  wrAddr_q, wrAddr_d;
  logic [LINE_W-1:0] readLine_q, readLine_d;
  logic              sameLine_q;
  rd_state_e         state_q, state_d;
  logic [IDX_W-1:0]  curPxl_q;
  logic              rdValid_q;
  logic [IDX_W-1:0]  rdIdx_q;
  logic [1:0]        rdTop_q;
  logic [LINE_W-1:0] rdLine_q;
  win3x3_t           win_q;

  logic [1:0]        wrBank;
  logic [3:0]        bankWe;
  logic              rdIssue;
  logic [IDX_W-1:0]  rdAddr;
  rgb555_t           bankData [4];
  logic [1:0]        rdCur, rdNext;
  rgb888_t           prevPx, curPx, nextPx;
  rgb888_t           inTop, inMid, inBot;

  assign wrBank = topPtr_q + 2'd3;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    lcc_line_bank #(.AW(IDX_W)) u_bank (
      .pxlClk   (pxlClk),
      .wrEn_i   (bankWe[b]),
      .wrAddr_i (wrAddr_q),
      .wrData_i (wrData_i),
      .rdAddr_i (rdAddr),
      .rdData_o (bankData[b])
    );
  end

  // Write side and bank rotation; a frame start overrides everything else.
  always_comb begin
    topPtr_d   = topPtr_q;
    complete_d = complete_q;
    wrAddr_d   = wrAddr_q;
    readLine_d = readLine_q;
    bankWe     = '0;
    if (wrEn_i && (wrAddr_q < END_IDX)) begin
      bankWe[wrBank] = 1'b1;
      wrAddr_d       = wrAddr_q + IDX_W'(1);
    end
    if (wrLineEnd_i) begin
      complete_d[wrBank] = 1'b1;
      wrAddr_d           = '0;
    end
    if (nextLine_i && (complete_q[wrBank] || wrLineEnd_i)) begin
      topPtr_d             = topPtr_q + 2'd1;
      complete_d[topPtr_q] = 1'b0;
      if (readLine_q != LAST_LINE) begin
        readLine_d = readLine_q + LINE_W'(1);
      end
    end
    if (wrFrameStart_i) begin
      bankWe     = '0;
      topPtr_d   = 2'd1;
      complete_d = '0;
      wrAddr_d   = '0;
      readLine_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    rdIssue = 1'b0;
    rdAddr  = '0;
    case (state_q)
      ST_PRIME0: begin
        rdIssue = 1'b1;
        state_d = ST_PRIME1;
      end
      ST_PRIME1: begin
        rdIssue = 1'b1;
        rdAddr  = IDX_W'(1);
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (curPxl_i != curPxl_q) begin
          rdIssue = 1'b1;
          rdAddr  = curPxl_i + IDX_W'(1);
        end
      end
      default: ;
    endcase
    if (cacheUpdate_i) begin
      state_d = ST_PRIME0;
    end
    if (wrFrameStart_i) begin
      state_d = ST_IDLE;
      rdIssue = 1'b0;
    end
  end

  // Incoming column built from the returned reads, with off-frame rows/columns substituted.
  assign rdCur  = rdTop_q + 2'd1;
  assign rdNext = rdTop_q + 2'd2;

  always_comb begin
    prevPx = expand555(bankData[rdTop_q]);
    curPx  = expand555(bankData[rdCur]);
    nextPx = expand555(bankData[rdNext]);
    inMid  = curPx;
    inTop  = (rdLine_q == '0) ? (CLAMP ? curPx : '0) : prevPx;
    inBot  = (rdLine_q == LAST_LINE) ? (CLAMP ? curPx : '0) : nextPx;
    if (rdIdx_q >= END_IDX) begin
      inTop = CLAMP ? win_q[2] : '0;
      inMid = CLAMP ? win_q[5] : '0;
      inBot = CLAMP ? win_q[8] : '0;
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      topPtr_q   <= '0;
      complete_q <= '0;
      wrAddr_q   <= '0;
      readLine_q <= '0;
      sameLine_q <= 1'b1;
      state_q    <= ST_IDLE;
      curPxl_q   <= '0;
      rdValid_q  <= 1'b0;
      rdIdx_q    <= '0;
      rdTop_q    <= '0;
      rdLine_q   <= '0;
    end else begin
      topPtr_q   <= topPtr_d;
      complete_q <= complete_d;
      wrAddr_q   <= wrAddr_d;
      readLine_q <= readLine_d;
      sameLine_q <= ~complete_q[wrBank];
      state_q    <= state_d;
      curPxl_q   <= curPxl_i;
      rdValid_q  <= rdIssue;
      if (rdIssue) begin
        rdIdx_q  <= rdAddr;
        rdTop_q  <= topPtr_q;
        rdLine_q <= readLine_q;
      end
    end
  end

  // Index 0 loads the left-edge column into the middle so the next read shifts it to the left.
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      win_q <= '0;
    end else if (rdValid_q) begin
      if (rdIdx_q == '0) begin
        win_q[1] <= CLAMP ? inTop : '0;
        win_q[4] <= CLAMP ? inMid : '0;
        win_q[7] <= CLAMP ? inBot : '0;
        win_q[2] <= inTop;
        win_q[5] <= inMid;
        win_q[8] <= inBot;
      end else begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= inTop;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= inMid;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= inBot;
      end
    end
  end

  assign sameLine_o = sameLine_q;
  assign win_o      = win_q;
  assign winValid_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_line_cache_ctrl.sv
// Directed bench for line_cache_ctrl; expected window values are hand-computed per step.
// Honours LCC_EDGE_CLAMP_EN for the edge expectations.
module tb_line_cache_ctrl;
  import line_cache_ctrl_pkg::*;

`ifdef LCC_EDGE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic       pxlClk = 1'b0;
  logic       rst;
  logic       wrFrameStart;
  logic       wrEn;
  rgb555_t    wrData;
  logic       wrLineEnd;
  logic [7:0] curPxl;
  logic       cacheUpdate;
  logic       nextLine;
  logic       sameLine;
  win3x3_t    win;
  logic       winValid;

  int checks   = 0;
  int failures = 0;

  always #5 pxlClk = ~pxlClk;

  line_cache_ctrl dut (
    .pxlClk         (pxlClk),
    .rst            (rst),
    .wrFrameStart_i (wrFrameStart),
    .wrEn_i         (wrEn),
    .wrData_i       (wrData),
    .wrLineEnd_i    (wrLineEnd),
    .curPxl_i       (curPxl),
    .cacheUpdate_i  (cacheUpdate),
    .nextLine_i     (nextLine),
    .sameLine_o     (sameLine),
    .win_o          (win),
    .winValid_o     (winValid)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge pxlClk);
  endtask

  // One-cycle control pulses.
  task automatic applyStimulus(input logic fs, input logic le, input logic nl, input logic cu);
    wrFrameStart = fs;
    wrLineEnd    = le;
    nextLine     = nl;
    cacheUpdate  = cu;
    tick(1);
    wrFrameStart = 1'b0;
    wrLineEnd    = 1'b0;
    nextLine     = 1'b0;
    cacheUpdate  = 1'b0;
  endtask

  task automatic writePixel(input rgb555_t d);
    wrEn   = 1'b1;
    wrData = d;
    tick(1);
    wrEn   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [215:0] obs, input logic [215:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expd);
    end
  endtask

  function automatic rgb888_t redOnly(input logic [4:0] c);
    return {c, c[4:2], 16'h0000};
  endfunction

  // Main directed sequence
  initial begin
    logic [7:0] k;
    rst = 1'b1; wrFrameStart = 1'b0; wrEn = 1'b0; wrData = '0; wrLineEnd = 1'b0;
    curPxl = '0; cacheUpdate = 1'b0; nextLine = 1'b0;
    tick(3);
    checkOutput("reset_sameLine", sameLine, 1'b1);
    checkOutput("reset_winValid", winValid, 1'b0);
    checkOutput("reset_win", win, 216'(0));
    rst = 1'b0;
    tick(1);

    // Line A into bank3 with 5 overflow writes that must be dropped
    $display("[TB] writing line A with 245 strobes");
    for (int i = 0; i < 245; i++) begin
      k = 8'(i);
      writePixel((i < 240) ? {k[4:0], 10'd0} : 15'h7C1F);
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    checkOutput("early_nextLine_sameLine", sameLine, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("complete_sameLine", sameLine, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    checkOutput("rotated_sameLine", sameLine, 1'b1);

    // Line B into bank0, then line end and next line together
    for (int i = 0; i < 240; i++) begin
      k = 8'(i + 3);
      writePixel({k[4:0], 10'd0});
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Display: cur = line A, next = line B
    $display("[TB] priming on line A and walking curPxl");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    checkOutput("prime_winValid", winValid, 1'b1);
    checkOutput("prime_MR", win[5], 24'h080000);
    checkOutput("prime_BM", win[7], 24'h180000);
    checkOutput("prime_BR", win[8], 24'h210000);
    checkOutput("prime_BL_edge", win[6], CLAMP ? 24'h180000 : 24'h000000);
    for (int i = 1; i < 240; i++) begin
      curPxl = 8'(i);
      k = 8'(i);
      tick(2);
      checkOutput($sformatf("walk_CM_%0d", i), win[4], redOnly(k[4:0]));
    end
    checkOutput("last_CM_kept", win[4], 24'h7B0000);
    checkOutput("last_ML", win[3], 24'h730000);
    checkOutput("last_BM", win[7], 24'h940000);
    checkOutput("last_MR_edge", win[5], CLAMP ? 24'h7B0000 : 24'h000000);
    checkOutput("last_BR_edge", win[8], CLAMP ? 24'h940000 : 24'h000000);

    // Rotate once more so bank2 becomes the write bank, then fill it partially
    writePixel(15'h0000);
    writePixel(15'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    writePixel(15'h7FFF);
    writePixel(15'h0421);
    writePixel(15'h1111);
    writePixel(15'h1111);
    writePixel(15'h1111);
    curPxl = 8'd0;
    tick(2);

    // Frame start mid-line and mid-run
    $display("[TB] frame start mid-line");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    checkOutput("frameStart_winValid", winValid, 1'b0);
    checkOutput("frameStart_sameLine", sameLine, 1'b1);

    // Top line of frame: cur = bank2, next = line A
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    checkOutput("top_winValid", winValid, 1'b1);
    checkOutput("top_CM", win[4], 24'hFFFFFF);
    checkOutput("top_MR", win[5], 24'h080808);
    checkOutput("top_TL", win[0], CLAMP ? 24'hFFFFFF : 24'h000000);
    checkOutput("top_TM", win[1], CLAMP ? 24'hFFFFFF : 24'h000000);
    checkOutput("top_TR", win[2], CLAMP ? 24'h080808 : 24'h000000);
    checkOutput("top_ML", win[3], CLAMP ? 24'hFFFFFF : 24'h000000);
    checkOutput("top_BR", win[8], 24'h080000);

    // New frame writes must land in bank0 from address 0
    writePixel(15'h001F);
    writePixel(15'h03E0);
    writePixel(15'h7C00);
    writePixel(15'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    checkOutput("l1_TM", win[1], 24'hFFFFFF);
    checkOutput("l1_TR", win[2], 24'h080808);
    checkOutput("l1_MR", win[5], 24'h080000);
    checkOutput("l1_BM_addr0", win[7], 24'h0000FF);
    checkOutput("l1_BR", win[8], 24'h00FF00);
    checkOutput("l1_TL_edge", win[0], CLAMP ? 24'hFFFFFF : 24'h000000);

    // Reset in the middle of a run
    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("preReset_sameLine", sameLine, 1'b0);
    rst = 1'b1;
    tick(1);
    checkOutput("midReset_win", win, 216'(0));
    checkOutput("midReset_winValid", winValid, 1'b0);
    checkOutput("midReset_sameLine", sameLine, 1'b1);
    rst = 1'b0;
    tick(3);
    checkOutput("postReset_idle", winValid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(4);
    checkOutput("postReset_reprimed", winValid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
